// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder: recovers hex nibbles from a multiplexed display bus.
// Optional SEVEN_SEG_ERRCNT_EN adds a saturating err_count output.
module seven_seg_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     valid_out,
    output logic                  frame_done,
    output logic                  err
`ifdef SEVEN_SEG_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [6:0]          seg_q, seg_prev_q;
    logic [DIGITS-1:0]   dig_q, dig_prev_q;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;
    logic                one_hot, match, capture;
    logic [4:0]          glyph;
    logic [DIGITS-1:0]   seen_nx;

    // Returns {legal, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return 5'h10;
            7'h06:   return 5'h11;
            7'h5B:   return 5'h12;
            7'h4F:   return 5'h13;
            7'h66:   return 5'h14;
            7'h6D:   return 5'h15;
            7'h7D:   return 5'h16;
            7'h07:   return 5'h17;
            7'h7F:   return 5'h18;
            7'h6F:   return 5'h19;
            7'h77:   return 5'h1A;
            7'h7C:   return 5'h1B;
            7'h39:   return 5'h1C;
            7'h5E:   return 5'h1D;
            7'h79:   return 5'h1E;
            7'h71:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    assign one_hot = $onehot(dig_q);
    assign match   = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
    assign glyph   = glyph_decode(seg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (!one_hot) begin
                    state_d = IDLE;
                end else if (!match) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(STABLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = CAPTURED;
                    end
                end
            end
            CAPTURED: begin
                if (!one_hot) begin
                    state_d = IDLE;
                end else if (!match) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        seen_nx = seen_q | dig_q;
        fd_d    = 1'b0;
        err_d   = 1'b0;
        if (capture) begin
            if (glyph[4]) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_q[i]) value_d[4*i +: 4] = glyph[3:0];
                end
                valid_d = valid_q | dig_q;
                // Completing the frame restarts tracking on the same edge.
                if (&seen_nx) begin
                    fd_d   = 1'b1;
                    seen_d = '0;
                end else begin
                    seen_d = seen_nx;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= '0;
            dig_q      <= '0;
            seg_prev_q <= '0;
            dig_prev_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            value_q    <= '0;
            valid_q    <= '0;
            seen_q     <= '0;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_q      <= SEG_ACTIVE_LOW ? ~seg_in : seg_in;
            dig_q      <= dig_en;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            fd_q       <= fd_d;
            err_q      <= err_d;
        end
    end

    assign value_out  = value_q;
    assign valid_out  = valid_q;
    assign frame_done = fd_q;
    assign err        = err_q;

`ifdef SEVEN_SEG_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errcnt_q <= '0;
        end else if (err_d && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign err_count = errcnt_q;
`endif

endmodule
